// File: rtl/twiddle_rotator.sv
// Radix-4 16-point twiddle rotator: multiplies each streamed 9.8 complex sample by W^(n[1:0]*n[3:2]).
// Two-stage valid/ready pipeline; e=0 and e=4 take exact bypass paths instead of the multipliers.
module twiddle_rotator (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [16:0] in_re,
  input  logic [16:0] in_im,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [16:0] out_re,
  output logic [16:0] out_im,
  output logic [3:0]  out_idx,
  output logic        out_last
);

  typedef enum logic [1:0] {MODE_MULT, MODE_PASS, MODE_NEGJ} mode_t;

  logic              en;
  logic [3:0]        n;
  logic [3:0]        e;
  logic signed [7:0] rom_c;
  logic signed [7:0] rom_d;
  mode_t             mode;

  logic              s1_valid;
  logic signed [16:0] s1_re;
  logic signed [16:0] s1_im;
  logic signed [7:0] s1_c;
  logic signed [7:0] s1_d;
  logic [3:0]        s1_idx;
  mode_t             s1_mode;

  logic signed [25:0] a_w, b_w, c_w, d_w;
  logic signed [25:0] prod_re, prod_im;
  logic signed [25:0] res_re, res_im;

  // A stalled output freezes the whole pipeline, so in_ready never looks at in_valid.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign e        = {2'b00, n[1:0]} * {2'b00, n[3:2]};

  // Twiddle ROM in Q1.7; exponents 5, 7 and 8 cannot occur for a 16-point frame.
  always_comb begin
    rom_c = 8'sd0;
    rom_d = 8'sd0;
    mode  = MODE_MULT;
    case (e)
      4'd0: mode = MODE_PASS;
      4'd1: begin rom_c =  8'sd118; rom_d = -8'sd49;  end
      4'd2: begin rom_c =  8'sd91;  rom_d = -8'sd91;  end
      4'd3: begin rom_c =  8'sd49;  rom_d = -8'sd118; end
      4'd4: mode = MODE_NEGJ;
      4'd6: begin rom_c = -8'sd91;  rom_d = -8'sd91;  end
      4'd9: begin rom_c = -8'sd118; rom_d =  8'sd49;  end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      n        <= 4'd0;
      s1_valid <= 1'b0;
      s1_re    <= '0;
      s1_im    <= '0;
      s1_c     <= '0;
      s1_d     <= '0;
      s1_idx   <= 4'd0;
      s1_mode  <= MODE_MULT;
    end else if (en) begin
      s1_valid <= in_valid;
      s1_re    <= in_re;
      s1_im    <= in_im;
      s1_c     <= rom_c;
      s1_d     <= rom_d;
      s1_idx   <= n;
      s1_mode  <= mode;
      if (in_valid)
        n <= n + 4'd1;
    end
  end

  // 26 bits hold the worst-case sum of two 17x8 products without overflow.
  always_comb begin
    a_w     = 26'(s1_re);
    b_w     = 26'(s1_im);
    c_w     = 26'(s1_c);
    d_w     = 26'(s1_d);
    prod_re = (a_w * c_w - b_w * d_w) >>> 7;
    prod_im = (a_w * d_w + b_w * c_w) >>> 7;
    res_re  = prod_re;
    res_im  = prod_im;
    case (s1_mode)
      MODE_PASS: begin res_re = a_w; res_im = b_w;  end
      MODE_NEGJ: begin res_re = b_w; res_im = -a_w; end
      default: ;
    endcase
  end

  function automatic logic [16:0] sat17(input logic signed [25:0] x);
    if (x > 26'sd65535)
      sat17 = 17'h0FFFF;
    else if (x < -26'sd65536)
      sat17 = 17'h10000;
    else
      sat17 = x[16:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
      out_idx   <= 4'd0;
      out_last  <= 1'b0;
    end else if (en) begin
      out_valid <= s1_valid;
      out_re    <= sat17(res_re);
      out_im    <= sat17(res_im);
      out_idx   <= s1_idx;
      out_last  <= (s1_idx == 4'd15);
    end
  end

endmodule

// File: doc/twiddle_rotator.md
TWIDDLE_ROTATOR -- requirements
Module: twiddle_rotator

Interface
REQ-001 The block SHALL have no parameters; all widths and the 16-point frame size SHALL be fixed.
REQ-002 The block SHALL have these ports:
- clk        input   1   sole clock; all state updates on its rising edge.
- rst        input   1   synchronous, active-high reset.
- in_valid   input   1   input sample present.
- in_ready   output  1   block accepts the input sample this cycle.
- in_re      input   17  input real part, 2's complement, 9.8 fixed point.
- in_im      input   17  input imaginary part, same format.
- out_valid  output  1   output sample present.
- out_ready  input   1   downstream accepts the output sample this cycle.
- out_re     output  17  rotated real part, 9.8.
- out_im     output  17  rotated imaginary part, 9.8.
- out_idx    output  4   index n of the output sample within its frame.
- out_last   output  1   high when out_idx = 15.
REQ-003 Reset SHALL be synchronous and active-high on rst, sampled on the rising edge of the single clock clk.

Function
REQ-004 An input transfer SHALL occur when in_valid and in_ready are both high; an output transfer SHALL occur when out_valid and out_ready are both high.
REQ-005 The 4-bit sample counter n SHALL increment on each input transfer and wrap from 15 to 0; it SHALL hold otherwise.
REQ-006 The twiddle exponent SHALL be e = n[1:0] * n[3:2], in the range 0..9, for radix-4 16-point decimation.
REQ-007 The twiddle W = c + j*d SHALL be read from an internal ROM of Q1.7 signed values, indexed by e:
- e=1: (118,-49); e=2: (91,-91); e=3: (49,-118); e=6: (-91,-91); e=9: (-118,49).
- e=0 and e=4 are special cases (REQ-008).
REQ-008 Two exponents SHALL bypass the multipliers and be exact:
- e=0: output equals input.
- e=4 (W = -j): out_re = in_im, out_im = -in_re, with -(-65536) saturating to 65535.
REQ-009 For other e, the products SHALL be computed at full precision and arithmetically shifted right by 7 (floor):
- re = (a*c - b*d) >>> 7; im = (a*d + b*c) >>> 7.
REQ-010 The re and im results SHALL then saturate to the 17-bit range [-65536, 65535].
REQ-011 The datapath SHALL be a 2-stage pipeline:
- stage 1: registers the input, n and the ROM twiddle.
- stage 2: registers the rounded and saturated result, out_idx and out_last.
REQ-012 Latency SHALL be exactly 2 clk cycles from input transfer to out_valid when out_ready is held high.
REQ-013 The pipeline advance enable SHALL be en = !out_valid || out_ready, and in_ready SHALL equal en; with out_ready held high, throughput SHALL be one sample per cycle.
REQ-014 While en is low, all pipeline registers, out_re, out_im, out_idx, out_last and out_valid SHALL hold stable.
REQ-015 Stage-valid bits SHALL propagate on en; a bubble (in_valid low) SHALL propagate as an invalid slot without advancing n.
REQ-016 Sample order SHALL be preserved, and no sample SHALL be dropped or duplicated under any out_ready pattern.
REQ-017 in_ready SHALL depend only on registered state and out_ready, with no combinational path from in_valid.

Reset
REQ-018 While rst is high, the following SHALL be cleared at the next clk edge: n, both stage-valid bits, out_valid, out_re, out_im, out_idx and out_last.
REQ-019 A reset asserted mid-frame SHALL discard in-flight samples, and the first input transfer after reset SHALL have n = 0.
REQ-020 in_ready SHALL be 1 during and after reset (pipeline empty).

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Reset: rst=1 for 2 cycles -> out_valid=0, out_re=out_im=0, in_ready=1; the next accepted sample reports out_idx=0.
- Bypass: sample n=0 with in=(-256,100), out_ready=1 -> 2 cycles later out=(-256,100), out_idx=0, out_last=0.
- Multiply: sample n=5 (e=1) with in=(256,0) -> out=(236,-98), out_idx=5.
- Exact -j: sample n=10 (e=4) with in=(300,-20) -> out=(-20,-300).
- Saturation: sample n=15 (e=9) with in=(-65536,-65536) -> out=(65535,35328), out_last=1.
- Backpressure: out_ready=0 while 3 samples are offered -> in_ready drops to 0 after 2 accepted, outputs held constant; after release all samples emerge in order with correct out_idx.
